// File: rtl/stack_call_ctrl.sv
// stack_call_ctrl: turns CALL/RET/FLUSH requests into clean stack strobes and one-cycle PC loads.
// Optional feature: define STACK_CALL_CTRL_GUARD_EN for overflow/underflow guarding with sticky OVF/UNF.
module stack_call_ctrl #(
  parameter int DATA_W = 19,
  parameter int STACK_DEPTH = 32,
  parameter int DEPTH_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CALL,
  input  logic              RET,
  input  logic              FLUSH,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic [DATA_W-1:0] TARGET_IN,
  input  logic [DATA_W-1:0] STK_DATA_IN,
  output logic [DATA_W-1:0] STK_DATA_OUT,
  output logic              STK_PUSH,
  output logic              STK_POP,
  output logic              STK_CLR,
  output logic [DATA_W-1:0] PC_OUT,
  output logic              PC_LOAD,
  output logic              BUSY,
  output logic [DEPTH_W-1:0] DEPTH,
  output logic              OVF,
  output logic              UNF
);
  typedef enum logic [2:0] {INIT, IDLE, C_SETUP, C_PUSH, P_POP, P_WAIT, LOAD, CLR} stateT;
  localparam logic [DATA_W-1:0] PC_STEP = 1;
  localparam logic [DEPTH_W-1:0] D_ONE = 1;
  localparam logic [DEPTH_W-1:0] D_TOP = DEPTH_W'(STACK_DEPTH);
  stateT state, nextState;
  logic [DATA_W-1:0] target;
  logic blocked, guardHit, full, empty;
  logic [DEPTH_W-1:0] depthUp, depthDn;
`ifdef STACK_CALL_CTRL_GUARD_EN
  assign full = DEPTH == D_TOP;
  assign empty = DEPTH == '0;
  assign depthUp = DEPTH + D_ONE;
  assign depthDn = DEPTH - D_ONE;
`else
  // Unguarded depth wraps with the stack's own pointer.
  assign full = 1'b0;
  assign empty = 1'b0;
  assign depthUp = DEPTH == D_TOP - D_ONE ? '0 : DEPTH + D_ONE;
  assign depthDn = DEPTH == '0 ? D_TOP - D_ONE : DEPTH - D_ONE;
`endif
  always_comb begin
    nextState = state;
    case (state)
      INIT:    nextState = STK_CLR ? IDLE : INIT;
      IDLE:    nextState = FLUSH ? CLR : CALL ? C_SETUP : RET ? P_POP : IDLE;
      C_SETUP: nextState = blocked ? IDLE : C_PUSH;
      C_PUSH:  nextState = LOAD;
      P_POP:   nextState = blocked ? IDLE : P_WAIT;
      P_WAIT:  nextState = LOAD;
      default: nextState = IDLE;
    endcase
    guardHit = state == IDLE && (nextState == C_SETUP ? full : nextState == P_POP && empty);
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      blocked <= 1'b0;
      target <= '0;
      STK_DATA_OUT <= '0;
      STK_PUSH <= 1'b0;
      STK_POP <= 1'b0;
      STK_CLR <= 1'b0;
      PC_OUT <= '0;
      PC_LOAD <= 1'b0;
      BUSY <= 1'b0;
      DEPTH <= '0;
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      state <= nextState;
      blocked <= guardHit;
      STK_PUSH <= nextState == C_PUSH;
      STK_POP <= nextState == P_POP && !guardHit;
      STK_CLR <= nextState == INIT || nextState == CLR;
      PC_LOAD <= nextState == LOAD;
      BUSY <= nextState != IDLE;
      if (nextState == C_SETUP && !guardHit) begin
        STK_DATA_OUT <= PC_IN + PC_STEP;
        target <= TARGET_IN;
      end
      if (nextState == LOAD) PC_OUT <= state == P_WAIT ? STK_DATA_IN : target;
      if (nextState == CLR || state == INIT) DEPTH <= '0;
      else if (state == C_PUSH) DEPTH <= depthUp;
      else if (state == P_POP && !blocked) DEPTH <= depthDn;
      OVF <= nextState != CLR && (OVF || (guardHit && nextState == C_SETUP));
      UNF <= nextState != CLR && (UNF || (guardHit && nextState == P_POP));
    end
  end
endmodule

// File: tb/tb_stack_call_ctrl.sv
// tb_stack_call_ctrl: directed scoreboard bench for stack_call_ctrl with a behavioural stack.
module tb_stack_call_ctrl;
`ifdef STACK_CALL_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1, CALL = 1'b0, RET = 1'b0, FLUSH = 1'b0;
  logic [18:0] PC_IN = '0, TARGET_IN = '0, STK_DATA_IN, STK_DATA_OUT, PC_OUT;
  logic STK_PUSH, STK_POP, STK_CLR, PC_LOAD, BUSY, OVF, UNF;
  logic [5:0] DEPTH;
  stack_call_ctrl dut (
    .CLK(CLK), .RST(RST), .CALL(CALL), .RET(RET), .FLUSH(FLUSH),
    .PC_IN(PC_IN), .TARGET_IN(TARGET_IN), .STK_DATA_IN(STK_DATA_IN),
    .STK_DATA_OUT(STK_DATA_OUT), .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_CLR(STK_CLR),
    .PC_OUT(PC_OUT), .PC_LOAD(PC_LOAD), .BUSY(BUSY), .DEPTH(DEPTH), .OVF(OVF), .UNF(UNF)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    int cyc;
    logic [3:0] strb;
    logic [18:0] data;
    logic [5:0] depth;
    logic ovf;
    logic unf;
  } evT;
  evT sb[$];
  int cyc = 0, nVec = 0, nBad = 0;
  logic [5:0] d = '0;
  logic ovf = 1'b0, unf = 1'b0;
  logic [18:0] mem [32];
  logic [4:0] sp;
  logic [18:0] rd;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) begin
    if (STK_CLR) sp <= '0;
    else if (STK_PUSH) begin
      mem[sp] <= STK_DATA_OUT;
      sp <= sp + 5'd1;
    end else if (STK_POP) begin
      sp <= sp - 5'd1;
      rd <= mem[sp - 5'd1];
    end
  end
  assign STK_DATA_IN = rd;
  always @(negedge CLK) begin
    evT e;
    logic [3:0] s;
    logic [18:0] dat;
    s = {STK_PUSH, STK_POP, STK_CLR, PC_LOAD};
    if (s != 4'b0) begin
      nVec++;
      dat = STK_PUSH ? STK_DATA_OUT : PC_LOAD ? PC_OUT : 19'h0;
      if (sb.size() == 0) begin
        nBad++;
        $display("FAIL unexpected_strobe: cyc %0d strobes %b data %h, required no strobe", cyc, s, dat);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || s !== e.strb || dat !== e.data || DEPTH !== e.depth ||
            OVF !== e.ovf || UNF !== e.unf || BUSY !== 1'b1) begin
          nBad++;
          $display("FAIL event: got cyc %0d strb %b data %h depth %0d ovf %b unf %b busy %b; required cyc %0d strb %b data %h depth %0d ovf %b unf %b busy 1",
                   cyc, s, dat, DEPTH, OVF, UNF, BUSY, e.cyc, e.strb, e.data, e.depth, e.ovf, e.unf);
        end
      end
    end
  end
  function automatic logic [5:0] wrapD(input int v);
    logic [5:0] r;
    r = 6'(v);
    return GUARD ? r : {1'b0, r[4:0]};
  endfunction
  task automatic addEv(input int c, input logic [3:0] s, input logic [18:0] dt, input logic [5:0] dp);
    evT e;
    e.cyc = c;
    e.strb = s;
    e.data = dt;
    e.depth = dp;
    e.ovf = ovf;
    e.unf = unf;
    sb.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  task automatic chkIdle(input string nm);
    chk({nm, "_busy"}, 32'(BUSY), 32'd0);
    chk({nm, "_depth"}, 32'(DEPTH), 32'(d));
    chk({nm, "_ovf"}, 32'(OVF), 32'(ovf));
    chk({nm, "_unf"}, 32'(UNF), 32'(unf));
  endtask
  task automatic req(input logic c, input logic r, input logic f,
                     input logic [18:0] pc, input logic [18:0] tg, input logic [18:0] rv);
    int n;
    @(negedge CLK);
    CALL = c;
    RET = r;
    FLUSH = f;
    PC_IN = pc;
    TARGET_IN = tg;
    n = cyc + 1;
    if (f) begin
      ovf = 1'b0;
      unf = 1'b0;
      d = '0;
      addEv(n, 4'b0010, 19'h0, d);
    end else if (c) begin
      if (GUARD && d == 6'd32) ovf = 1'b1;
      else begin
        addEv(n + 1, 4'b1000, pc + 19'd1, d);
        d = wrapD(int'(d) + 1);
        addEv(n + 2, 4'b0001, tg, d);
      end
    end else if (r) begin
      if (GUARD && d == 6'd0) unf = 1'b1;
      else begin
        addEv(n, 4'b0100, 19'h0, d);
        d = wrapD(int'(d) - 1);
        addEv(n + 2, 4'b0001, rv, d);
      end
    end
    @(negedge CLK);
    CALL = 1'b0;
    RET = 1'b0;
    FLUSH = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", 32'({STK_PUSH, STK_POP, STK_CLR, PC_LOAD, BUSY, OVF, UNF}), 32'd0);
    RST = 1'b0;
    addEv(cyc + 1, 4'b0010, 19'h0, 6'd0);
    repeat (4) @(negedge CLK);
    chkIdle("after_init");
    req(1'b1, 1'b0, 1'b0, 19'h00100, 19'h02000, 19'h0);
    RET = 1'b1;
    @(negedge CLK);
    RET = 1'b0;
    repeat (2) @(negedge CLK);
    chkIdle("first_call");
    req(1'b0, 1'b1, 1'b0, 19'h0, 19'h0, 19'h00101);
    repeat (3) @(negedge CLK);
    chkIdle("first_ret");
    for (int i = 0; i < 33; i++) begin
      req(1'b1, 1'b0, 1'b0, 19'h01000 + 19'(i), 19'h04000 + 19'(i), 19'h0);
      repeat (3) @(negedge CLK);
    end
    chkIdle("after_33_calls");
    req(1'b0, 1'b0, 1'b1, 19'h0, 19'h0, 19'h0);
    repeat (3) @(negedge CLK);
    chkIdle("flush");
    req(1'b0, 1'b1, 1'b0, 19'h0, 19'h0, 19'h01020);
    repeat (3) @(negedge CLK);
    chkIdle("ret_at_empty");
    req(1'b0, 1'b0, 1'b1, 19'h0, 19'h0, 19'h0);
    repeat (3) @(negedge CLK);
    chkIdle("flush_clears_unf");
    req(1'b1, 1'b1, 1'b0, 19'h7FFFF, 19'h12345, 19'h0);
    repeat (3) @(negedge CLK);
    chkIdle("call_beats_ret");
    req(1'b1, 1'b0, 1'b1, 19'h00200, 19'h00300, 19'h0);
    repeat (3) @(negedge CLK);
    chkIdle("flush_beats_call");
    req(1'b1, 1'b0, 1'b0, 19'h00500, 19'h00600, 19'h0);
    void'(sb.pop_back());
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_push_low", 32'({STK_PUSH, PC_LOAD, BUSY}), 32'd0);
    RST = 1'b0;
    d = '0;
    ovf = 1'b0;
    unf = 1'b0;
    addEv(cyc + 1, 4'b0010, 19'h0, 6'd0);
    repeat (5) @(negedge CLK);
    chkIdle("after_abort");
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
